lvds_frame_aligner: RTL and testbench
=====================================

Name: lvds_frame_aligner

Overview:
- Sits directly downstream of the 1:14 DDR deserializer on the frame-clock lane of the ADC LVDS interface.
- Watches the 14-bit parallel frame word produced on the divided clock and issues single-cycle BITSLIP pulses until the word matches the ADC frame pattern.
- Reports lock; the same BITSLIP is fanned out to the data-lane deserializers.
- Monitors lock continuously and realigns automatically on loss of lock.

Parameters:
- DATA_WIDTH, 14, width of the deserialized frame word
- FRAME_PATTERN, 14'b11111110000000 (0x3F80), expected aligned frame word
- SETTLE_CYCLES, 4, CLKDIV cycles to wait after a bitslip or start before comparing
- MATCH_COUNT, 16, consecutive matches required to declare lock
- MAX_SLIPS, 14, bitslips attempted before declaring failure
- MISS_LIMIT, 3, consecutive mismatches while locked that drop lock

Ports:
- CLKDIV  in  1  divided (word) clock; the only clock
- RST  in  1  synchronous, active-high reset
- START  in  1  single-cycle request to (re)start alignment
- FRAME  in  DATA_WIDTH  parallel frame word from the deserializer Q output
- BITSLIP  out  1  single-cycle bitslip pulse to the deserializer(s)
- ALIGNED  out  1  frame lock achieved
- ALIGN_ERR  out  1  sticky failure flag
- SLIP_CNT  out  4  number of bitslips issued in the current attempt

Behaviour:
- Clocking and reset: one clock, CLKDIV. RST is synchronous and active-high, sampled on the CLKDIV rising edge.
- Reset values: BITSLIP=0, ALIGNED=0, ALIGN_ERR=0, SLIP_CNT=0, all internal counters 0, state IDLE.
- Outputs are registered.
- RST overrides everything, including mid-operation; no pulse completes after RST.
- States:
  - IDLE: outputs hold. START -> SETTLE, with SLIP_CNT and counters cleared and ALIGN_ERR cleared.
  - SETTLE: waits exactly SETTLE_CYCLES cycles (settle counter 0..SETTLE_CYCLES-1), then -> CHECK with match counter cleared.
  - CHECK: compares FRAME == FRAME_PATTERN every cycle.
    - Match: match counter +1. When the counter reaches MATCH_COUNT -> LOCKED; ALIGNED=1 on the same edge as the state change.
    - Mismatch: match counter cleared. If SLIP_CNT == MAX_SLIPS -> FAIL, else -> SLIP.
  - SLIP: BITSLIP=1 for exactly this one cycle, SLIP_CNT+1, then -> SETTLE.
  - LOCKED: ALIGNED=1.
    - Mismatch: miss counter +1. Match: miss counter cleared.
    - When the miss counter reaches MISS_LIMIT: ALIGNED=0, SLIP_CNT=0, -> SETTLE (automatic relock).
  - FAIL: ALIGN_ERR=1, ALIGNED=0, BITSLIP=0. Stays in FAIL until START or RST.
- START in any non-IDLE state restarts: SLIP_CNT, counters and ALIGNED cleared, -> SETTLE. START has priority over the compare result in the same cycle.
- BITSLIP spacing: never high in two consecutive cycles. The minimum gap between pulses is SETTLE_CYCLES+1 cycles, because the deserializer output lags a bitslip by 2–3 CLKDIV.
- Latency with the word already aligned: START at cycle 0; ALIGNED high after cycle 1+SETTLE_CYCLES+MATCH_COUNT (21 with defaults).
- Width rules:
  - SLIP_CNT saturates at MAX_SLIPS and never wraps.
  - Counters are sized clog2(max+1).
  - The compare is over the full DATA_WIDTH; no masking.

Decomposition:
- Shared package lvds_pkg holds:
  - the state enumeration (IDLE, SETTLE, CHECK, SLIP, LOCKED, FAIL)
  - the default FRAME_PATTERN constant
  - DATA_WIDTH
- No sub-module; a single FSM with three counters (settle, match, miss) is natural at this size.

Test Plan:
1. Aligned input: after RST, FRAME=0x3F80 constant, START pulse at cycle 0 -> BITSLIP never asserted, ALIGNED rises at cycle 21, SLIP_CNT=0.
2. Rotated input: bench model presents the pattern rotated left by 5 and rotates by 1 per BITSLIP -> exactly 5 one-cycle BITSLIP pulses, each at least 5 cycles apart, then ALIGNED=1 with SLIP_CNT=5.
3. No pattern: FRAME=0x0000 -> 14 BITSLIP pulses, then ALIGN_ERR=1, ALIGNED=0, SLIP_CNT=14, no further pulses. A later START clears ALIGN_ERR.
4. Lock loss:
   - While locked, inject 2 consecutive mismatches -> ALIGNED stays 1.
   - Then inject 3 consecutive mismatches -> ALIGNED=0 on the edge after the third, SLIP_CNT=0, realignment restarts with SETTLE.
5. Glitch in CHECK: 10 matches, 1 mismatch -> one BITSLIP, SLIP_CNT=1, match counter restarts; ALIGNED needs 16 fresh matches.
6. Reset and restart mid-operation:
   - RST asserted during SETTLE of the 3rd slip -> all outputs take reset values on the next edge.
   - START during LOCKED -> ALIGNED=0 next edge, re-lock after 21 cycles.

Source files
------------

// File: rtl/lvds_pkg.sv
// Shared state encoding and default frame parameters for the LVDS frame-clock aligner.
package lvds_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 14;
  localparam logic [DEFAULT_DATA_WIDTH-1:0] DEFAULT_FRAME_PATTERN = 14'b11111110000000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_SLIP,
    ST_LOCKED,
    ST_FAIL
  } align_state_e;

endpackage

// File: rtl/lvds_frame_aligner.sv
// Bitslip controller for the ADC frame-clock lane: slips the deserializer until the
// parallel frame word matches the ADC frame pattern, then monitors lock.
module lvds_frame_aligner
  import lvds_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] FRAME_PATTERN = DATA_WIDTH'(DEFAULT_FRAME_PATTERN),
  parameter int unsigned           SETTLE_CYCLES = 4,
  parameter int unsigned           MATCH_COUNT   = 16,
  parameter int unsigned           MAX_SLIPS     = 14,
  parameter int unsigned           MISS_LIMIT    = 3
) (
  input  logic                  CLKDIV,
  input  logic                  RST,
  input  logic                  START,
  input  logic [DATA_WIDTH-1:0] FRAME,
  output logic                  BITSLIP,
  output logic                  ALIGNED,
  output logic                  ALIGN_ERR,
  output logic [3:0]            SLIP_CNT
);

  localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned MATCH_W  = $clog2(MATCH_COUNT + 1);
  localparam int unsigned MISS_W   = $clog2(MISS_LIMIT + 1);

  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [MATCH_W-1:0]  MATCH_LAST  = MATCH_W'(MATCH_COUNT - 1);
  localparam logic [MISS_W-1:0]   MISS_LAST   = MISS_W'(MISS_LIMIT - 1);
  localparam logic [3:0]          SLIP_MAX    = 4'(MAX_SLIPS);

  align_state_e        state_q, state_d;
  logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [MATCH_W-1:0]  match_cnt_q, match_cnt_d;
  logic [MISS_W-1:0]   miss_cnt_q, miss_cnt_d;
  logic [3:0]          slip_cnt_q, slip_cnt_d;
  logic                bitslip_q, bitslip_d;
  logic                aligned_q, aligned_d;
  logic                align_err_q, align_err_d;
  logic                frame_match;

  assign frame_match = (FRAME == FRAME_PATTERN);

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    match_cnt_d  = match_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    slip_cnt_d   = slip_cnt_q;
    bitslip_d    = 1'b0;
    aligned_d    = aligned_q;
    align_err_d  = align_err_q;

    // START wins over any compare result and restarts from a clean attempt.
    if (START) begin
      state_d      = ST_SETTLE;
      settle_cnt_d = '0;
      match_cnt_d  = '0;
      miss_cnt_d   = '0;
      slip_cnt_d   = '0;
      aligned_d    = 1'b0;
      align_err_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
        end

        ST_SETTLE: begin
          if (settle_cnt_q == SETTLE_LAST) begin
            state_d     = ST_CHECK;
            match_cnt_d = '0;
          end else begin
            settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
          end
        end

        ST_CHECK: begin
          if (frame_match) begin
            match_cnt_d = match_cnt_q + MATCH_W'(1);
            if (match_cnt_q == MATCH_LAST) begin
              state_d    = ST_LOCKED;
              aligned_d  = 1'b1;
              miss_cnt_d = '0;
            end
          end else begin
            match_cnt_d = '0;
            if (slip_cnt_q == SLIP_MAX) begin
              state_d     = ST_FAIL;
              align_err_d = 1'b1;
              aligned_d   = 1'b0;
            end else begin
              // The pulse is registered, so it is high exactly while in SLIP.
              state_d    = ST_SLIP;
              bitslip_d  = 1'b1;
              slip_cnt_d = slip_cnt_q + 4'd1;
            end
          end
        end

        ST_SLIP: begin
          state_d      = ST_SETTLE;
          settle_cnt_d = '0;
        end

        ST_LOCKED: begin
          if (frame_match) begin
            miss_cnt_d = '0;
          end else if (miss_cnt_q == MISS_LAST) begin
            state_d      = ST_SETTLE;
            settle_cnt_d = '0;
            match_cnt_d  = '0;
            miss_cnt_d   = '0;
            slip_cnt_d   = '0;
            aligned_d    = 1'b0;
          end else begin
            miss_cnt_d = miss_cnt_q + MISS_W'(1);
          end
        end

        ST_FAIL: begin
          aligned_d   = 1'b0;
          align_err_d = 1'b1;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLKDIV) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= '0;
      match_cnt_q  <= '0;
      miss_cnt_q   <= '0;
      slip_cnt_q   <= '0;
      bitslip_q    <= 1'b0;
      aligned_q    <= 1'b0;
      align_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      match_cnt_q  <= match_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      slip_cnt_q   <= slip_cnt_d;
      bitslip_q    <= bitslip_d;
      aligned_q    <= aligned_d;
      align_err_q  <= align_err_d;
    end
  end

  assign BITSLIP   = bitslip_q;
  assign ALIGNED   = aligned_q;
  assign ALIGN_ERR = align_err_q;
  assign SLIP_CNT  = slip_cnt_q;

endmodule

// File: tb/tb_lvds_frame_aligner.sv
// Self-checking bench for lvds_frame_aligner: a rotating-deserializer model feeds the DUT
// and expected event times are derived from the slip/settle/compare timing rules.
module tb_lvds_frame_aligner;

  localparam int W          = 14;
  localparam logic [W-1:0] PATTERN = 14'h3F80;
  localparam int SETTLE     = 4;
  localparam int MATCHES    = 16;
  localparam int MAX_SLIPS  = 14;
  localparam int MISS_LIMIT = 3;
  // One attempt = slip cycle + settle window + one failing compare.
  localparam int SLIP_PERIOD  = SETTLE + 2;
  localparam int LOCK_LATENCY = 1 + SETTLE + MATCHES;

  logic         clkdiv = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] frame = '0;
  logic         bitslip;
  logic         aligned;
  logic         align_err;
  logic [3:0]   slip_cnt;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [W-1:0] base_word = '0;
  logic [W-1:0] bad_word = '0;
  int           applied = 0;
  int           bad_left = 0;
  bit           follow_slips = 1'b1;
  int           pending[$];
  int           pulses[$];

  lvds_frame_aligner #(
    .DATA_WIDTH   (W),
    .FRAME_PATTERN(PATTERN),
    .SETTLE_CYCLES(SETTLE),
    .MATCH_COUNT  (MATCHES),
    .MAX_SLIPS    (MAX_SLIPS),
    .MISS_LIMIT   (MISS_LIMIT)
  ) dut (
    .CLKDIV   (clkdiv),
    .RST      (rst),
    .START    (start),
    .FRAME    (frame),
    .BITSLIP  (bitslip),
    .ALIGNED  (aligned),
    .ALIGN_ERR(align_err),
    .SLIP_CNT (slip_cnt)
  );

  always #5 clkdiv = ~clkdiv;

  function automatic logic [W-1:0] rotr(input logic [W-1:0] w, input int n);
    logic [2*W-1:0] d;
    d = {w, w} >> (n % W);
    return d[W-1:0];
  endfunction

  function automatic logic [W-1:0] rotl(input logic [W-1:0] w, input int n);
    return rotr(w, W - (n % W));
  endfunction

  // Slips needed before the deserializer presents the pattern, or -1 if it never does in budget.
  function automatic int expected_slips(input logic [W-1:0] w);
    for (int k = 0; k <= MAX_SLIPS; k++) begin
      if (rotr(w, k) == PATTERN) return k;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Advance one cycle; observe outputs at the falling edge and drive the next frame word.
  task automatic stepCycle();
    int tmp;
    @(negedge clkdiv);
    cyc++;
    if (bitslip === 1'b1) begin
      pulses.push_back(cyc);
      if (follow_slips) pending.push_back(cyc + 2 + int'($urandom_range(0, 1)));
    end
    while (pending.size() > 0 && pending[0] <= cyc) begin
      tmp = pending.pop_front();
      applied++;
    end
    if (bad_left > 0) begin
      frame = bad_word;
      bad_left--;
    end else begin
      frame = rotr(base_word, applied);
    end
  endtask

  task automatic applyStimulus(input logic rst_v, input logic start_v, output int at_cyc);
    rst    = rst_v;
    start  = start_v;
    at_cyc = cyc;
    stepCycle();
    rst    = 1'b0;
    start  = 1'b0;
  endtask

  task automatic newTrial(input logic [W-1:0] base);
    int d;
    applyStimulus(1'b1, 1'b0, d);
    pending.delete();
    pulses.delete();
    applied      = 0;
    bad_left     = 0;
    follow_slips = 1'b1;
    base_word    = base;
    frame        = base;
  endtask

  task automatic waitOutcome(input int start_c, input int budget, output int lock_rel,
                             output int err_rel);
    do begin
      stepCycle();
    end while (aligned !== 1'b1 && align_err !== 1'b1 && (cyc - start_c) < budget);
    lock_rel = (aligned === 1'b1) ? cyc - start_c : -1;
    err_rel  = (align_err === 1'b1) ? cyc - start_c : -1;
  endtask

  function automatic int pulse_rel(input int j, input int start_c);
    if (j < pulses.size()) return pulses[j] - start_c;
    return -1;
  endfunction

  task automatic runAlignTrial(input logic [W-1:0] base, input string tag);
    int k, s, s2, lock_rel, err_rel, n_exp;
    k = expected_slips(base);
    newTrial(base);
    applyStimulus(1'b0, 1'b1, s);
    waitOutcome(s, 200, lock_rel, err_rel);
    n_exp = (k >= 0) ? k : MAX_SLIPS;
    if (k >= 0) begin
      checkOutput({tag, "_lock_cycle"}, lock_rel, LOCK_LATENCY + k * SLIP_PERIOD);
      checkOutput({tag, "_slip_cnt"}, int'(slip_cnt), k);
      checkOutput({tag, "_err_low"}, int'(align_err), 0);
    end else begin
      checkOutput({tag, "_err_cycle"}, err_rel, (MAX_SLIPS + 1) * SLIP_PERIOD);
      checkOutput({tag, "_slip_cnt_sat"}, int'(slip_cnt), MAX_SLIPS);
      checkOutput({tag, "_aligned_low"}, int'(aligned), 0);
      repeat (30) stepCycle();
      checkOutput({tag, "_err_sticky"}, int'(align_err), 1);
    end
    checkOutput({tag, "_pulse_count"}, pulses.size(), n_exp);
    for (int j = 0; j < n_exp; j++) begin
      checkOutput({tag, "_pulse_time"}, pulse_rel(j, s), (j + 1) * SLIP_PERIOD);
    end
    if (k < 0) begin
      applyStimulus(1'b0, 1'b1, s2);
      checkOutput({tag, "_err_cleared"}, int'(align_err), 0);
      checkOutput({tag, "_slip_cnt_cleared"}, int'(slip_cnt), 0);
    end
  endtask

  task automatic runGlitchTrial(input int g);
    int s, lock_rel, err_rel;
    newTrial(PATTERN);
    follow_slips = 1'b0;
    bad_word     = PATTERN ^ W'($urandom_range(1, (1 << W) - 1));
    applyStimulus(1'b0, 1'b1, s);
    while (cyc < s + SETTLE + g) stepCycle();
    bad_left = 1;
    waitOutcome(s, 200, lock_rel, err_rel);
    checkOutput("glitch_pulse_count", pulses.size(), 1);
    checkOutput("glitch_pulse_time", pulse_rel(0, s), SETTLE + 2 + g);
    checkOutput("glitch_lock_cycle", lock_rel, SETTLE + 2 + g + LOCK_LATENCY);
    checkOutput("glitch_slip_cnt", int'(slip_cnt), 1);
  endtask

  initial begin
    int s, d, lock_rel, err_rel, low_count, third, r;

    applyStimulus(1'b1, 1'b0, d);
    applyStimulus(1'b1, 1'b0, d);
    checkOutput("rst_bitslip", int'(bitslip), 0);
    checkOutput("rst_aligned", int'(aligned), 0);
    checkOutput("rst_align_err", int'(align_err), 0);
    checkOutput("rst_slip_cnt", int'(slip_cnt), 0);

    runAlignTrial(PATTERN, "aligned");
    runAlignTrial(rotl(PATTERN, 5), "rot5");
    repeat (4) runAlignTrial(rotl(PATTERN, int'($urandom_range(1, 13))), "rot_rand");
    runAlignTrial(rotl(PATTERN, 13), "rot13");
    runAlignTrial('0, "zero");
    repeat (3) runAlignTrial(W'($urandom), "word_rand");

    // Lock loss: two misses are tolerated, three drop lock and restart alignment.
    newTrial(PATTERN);
    applyStimulus(1'b0, 1'b1, s);
    waitOutcome(s, 200, lock_rel, err_rel);
    checkOutput("loss_initial_lock", lock_rel, LOCK_LATENCY);
    repeat (int'($urandom_range(1, 5))) stepCycle();
    bad_word = PATTERN ^ W'($urandom_range(1, (1 << W) - 1));
    bad_left = 2;
    low_count = 0;
    repeat (6) begin
      stepCycle();
      if (aligned !== 1'b1) low_count++;
    end
    checkOutput("loss_two_miss_hold", low_count, 0);
    bad_left = 3;
    stepCycle();
    third = cyc + 2;
    stepCycle();
    stepCycle();
    checkOutput("loss_before_third", int'(aligned), 1);
    stepCycle();
    checkOutput("loss_after_third", int'(aligned), 0);
    checkOutput("loss_slip_cnt", int'(slip_cnt), 0);
    waitOutcome(third, 200, lock_rel, err_rel);
    checkOutput("loss_relock_cycle", lock_rel, LOCK_LATENCY);
    checkOutput("loss_no_pulses", pulses.size(), 0);

    runGlitchTrial(10);
    runGlitchTrial(int'($urandom_range(0, MATCHES - 1)));

    // Reset during the settle window that follows the third slip.
    newTrial(rotl(PATTERN, 5));
    applyStimulus(1'b0, 1'b1, s);
    r = s + 3 * SLIP_PERIOD + 1 + int'($urandom_range(0, SETTLE - 1));
    while (cyc < r) stepCycle();
    checkOutput("midrst_slip_cnt_before", int'(slip_cnt), 3);
    applyStimulus(1'b1, 1'b0, d);
    checkOutput("midrst_bitslip", int'(bitslip), 0);
    checkOutput("midrst_aligned", int'(aligned), 0);
    checkOutput("midrst_align_err", int'(align_err), 0);
    checkOutput("midrst_slip_cnt", int'(slip_cnt), 0);
    repeat (3 * SLIP_PERIOD) stepCycle();
    checkOutput("midrst_idle_pulses", pulses.size(), 3);
    checkOutput("midrst_idle_aligned", int'(aligned), 0);

    // START while locked drops lock at once and relocks after the full latency.
    newTrial(PATTERN);
    applyStimulus(1'b0, 1'b1, s);
    waitOutcome(s, 200, lock_rel, err_rel);
    checkOutput("restart_first_lock", lock_rel, LOCK_LATENCY);
    repeat (int'($urandom_range(1, 5))) stepCycle();
    applyStimulus(1'b0, 1'b1, s);
    checkOutput("restart_aligned_drop", int'(aligned), 0);
    waitOutcome(s, 200, lock_rel, err_rel);
    checkOutput("restart_relock", lock_rel, LOCK_LATENCY);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
